// File: rtl/ysyx_22040759_define.sv
// Shared decode codes, opcode constants and decoded-bundle layout for the IDU/EXU.
// A stage register holds {pc, imm[XLEN-1:0], ctrl_t}; EXU slices it with the offsets below.
package ysyx_22040759_define;

    typedef enum logic [4:0] {
        ALU_NOP = 5'd0, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    typedef enum logic [1:0] {A_REG = 2'd0, A_PC, A_ZERO} a_sel_e;
    typedef enum logic [1:0] {B_REG = 2'd0, B_IMM} b_sel_e;
    typedef enum logic [2:0] {BR_NONE = 3'd0, BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU} br_op_e;
    typedef enum logic [1:0] {JMP_NONE = 2'd0, JMP_JAL, JMP_JALR} jump_e;
    typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM, WB_PC4} wb_sel_e;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [31:0] INST_EBREAK  = 32'h0010_0073;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        alu_op_e    alu_op;
        a_sel_e     a_sel;
        b_sel_e     b_sel;
        logic       word;
        br_op_e     br_op;
        jump_e      jump;
        logic       reg_wen;
        wb_sel_e    wb_sel;
        logic       mem_ren;
        logic       mem_wen;
        logic [2:0] mem_size;
        logic       illegal;
        logic       ebreak;
    } ctrl_t;

    localparam int CTRL_W         = $bits(ctrl_t);
    localparam int BUNDLE_IMM_LSB = CTRL_W;

    function automatic int bundle_w(input int xlen);
        return xlen + CTRL_W;
    endfunction

    // funct3 -> ALU op; alt selects SUB/SRA (inst[30]) where that encoding exists.
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22040759_idu_dec.sv
// Combinational RV32I/RV64I decoder: instruction word -> immediate and control bundle.
import ysyx_22040759_define::*;

module ysyx_22040759_idu_dec #(
    parameter int XLEN = 64
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output ctrl_t           ctrl
);
    localparam bit RV64 = (XLEN == 64);

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic            legal;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opc   = inst[6:0];
    assign f3    = inst[14:12];
    assign f7    = inst[31:25];
    assign imm_i = XLEN'($signed(inst[31:20]));
    assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

    always_comb begin
        ctrl      = '0;
        imm       = '0;
        legal     = 1'b0;
        ctrl.rs1  = inst[19:15];
        ctrl.rs2  = inst[24:20];
        ctrl.rd   = inst[11:7];
        case (opc)
            OPC_LUI, OPC_AUIPC: begin
                legal        = 1'b1;
                ctrl.alu_op  = ALU_ADD;
                ctrl.a_sel   = (opc == OPC_LUI) ? A_ZERO : A_PC;
                ctrl.b_sel   = B_IMM;
                ctrl.reg_wen = 1'b1;
                imm          = imm_u;
            end
            OPC_JAL, OPC_JALR: begin
                legal        = (opc == OPC_JAL) || (f3 == 3'b000);
                ctrl.alu_op  = ALU_ADD;
                ctrl.a_sel   = (opc == OPC_JAL) ? A_PC : A_REG;
                ctrl.b_sel   = B_IMM;
                ctrl.jump    = (opc == OPC_JAL) ? JMP_JAL : JMP_JALR;
                ctrl.reg_wen = 1'b1;
                ctrl.wb_sel  = WB_PC4;
                imm          = (opc == OPC_JAL) ? imm_j : imm_i;
            end
            OPC_BRANCH: begin
                legal       = (f3[2:1] != 2'b01);
                ctrl.alu_op = ALU_SUB;
                imm         = imm_b;
                case (f3)
                    3'b000:  ctrl.br_op = BR_BEQ;
                    3'b001:  ctrl.br_op = BR_BNE;
                    3'b100:  ctrl.br_op = BR_BLT;
                    3'b101:  ctrl.br_op = BR_BGE;
                    3'b110:  ctrl.br_op = BR_BLTU;
                    3'b111:  ctrl.br_op = BR_BGEU;
                    default: ctrl.br_op = BR_NONE;
                endcase
            end
            OPC_LOAD: begin
                legal         = (f3 != 3'b111) && (RV64 || (f3 != 3'b011 && f3 != 3'b110));
                ctrl.alu_op   = ALU_ADD;
                ctrl.b_sel    = B_IMM;
                ctrl.reg_wen  = 1'b1;
                ctrl.wb_sel   = WB_MEM;
                ctrl.mem_ren  = 1'b1;
                ctrl.mem_size = f3;
                imm           = imm_i;
            end
            OPC_STORE: begin
                legal         = !f3[2] && (RV64 || f3 != 3'b011);
                ctrl.alu_op   = ALU_ADD;
                ctrl.b_sel    = B_IMM;
                ctrl.mem_wen  = 1'b1;
                ctrl.mem_size = f3;
                imm           = imm_s;
            end
            OPC_OP_IMM, OPC_OP_IMM_32: begin
                // RV64 shifts take a 6-bit shamt, so inst[25] is only legal there (and never for *W).
                case (f3)
                    3'b000:  legal = 1'b1;
                    3'b001:  legal = (inst[31:26] == 6'b0);
                    3'b101:  legal = (inst[31:26] == 6'b0) || (inst[31:26] == 6'b010000);
                    default: legal = (opc == OPC_OP_IMM);
                endcase
                if (f3[1:0] == 2'b01 && inst[25] && (!RV64 || opc == OPC_OP_IMM_32))
                    legal = 1'b0;
                if (opc == OPC_OP_IMM_32 && !RV64)
                    legal = 1'b0;
                ctrl.word    = (opc == OPC_OP_IMM_32);
                ctrl.alu_op  = alu_from_f3(f3, (f3 == 3'b101) && inst[30]);
                ctrl.b_sel   = B_IMM;
                ctrl.reg_wen = 1'b1;
                imm          = imm_i;
            end
            OPC_OP, OPC_OP_32: begin
                legal = (f7 == 7'b0) || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
                if (opc == OPC_OP_32)
                    legal = legal && RV64 && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101);
                ctrl.word    = (opc == OPC_OP_32);
                ctrl.alu_op  = alu_from_f3(f3, inst[30]);
                ctrl.reg_wen = 1'b1;
            end
            OPC_MISC_MEM: legal = (f3 == 3'b000);
            OPC_SYSTEM: begin
                legal       = (inst == INST_EBREAK);
                ctrl.ebreak = legal;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            ctrl         = '0;
            ctrl.rs1     = inst[19:15];
            ctrl.rs2     = inst[24:20];
            ctrl.rd      = inst[11:7];
            ctrl.illegal = 1'b1;
            imm          = '0;
        end
        if (ctrl.rd == 5'd0)
            ctrl.reg_wen = 1'b0;
    end

endmodule

// File: rtl/ysyx_22040759_idu_stage.sv
// Registered decode stage: valid/ready on both sides, main + skid register, flush.
import ysyx_22040759_define::*;

module ysyx_22040759_idu_stage #(
    parameter int XLEN = 64,
    parameter int PC_W = XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_inst,
    input  logic [PC_W-1:0] if_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [PC_W-1:0] id_pc,
    output logic [XLEN-1:0] id_imm,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [4:0]      id_rd,
    output logic [4:0]      id_alu_op,
    output logic [1:0]      id_a_sel,
    output logic [1:0]      id_b_sel,
    output logic            id_word,
    output logic [2:0]      id_br_op,
    output logic [1:0]      id_jump,
    output logic            id_reg_wen,
    output logic [1:0]      id_wb_sel,
    output logic            id_mem_ren,
    output logic            id_mem_wen,
    output logic [2:0]      id_mem_size,
    output logic            id_illegal,
    output logic            id_ebreak
);
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [XLEN-1:0] imm;
        ctrl_t           ctrl;
    } bundle_t;

    bundle_t         main_q, main_d, skid_q, skid_d, dec_bundle;
    logic            main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic            accept;
    logic [XLEN-1:0] dec_imm;
    ctrl_t           dec_ctrl;

    ysyx_22040759_idu_dec #(.XLEN(XLEN)) u_dec (
        .inst (if_inst),
        .imm  (dec_imm),
        .ctrl (dec_ctrl)
    );

    assign dec_bundle = {if_pc, dec_imm, dec_ctrl};
    assign if_ready   = !skid_v_q;
    assign accept     = if_valid && if_ready;

    // Skid is only ever filled behind a valid main entry, so skid is always the younger one.
    always_comb begin
        main_v_d = main_v_q;
        main_d   = main_q;
        skid_v_d = skid_v_q;
        skid_d   = skid_q;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!main_v_q || id_ready) begin
            if (skid_v_q) begin
                main_v_d = 1'b1;
                main_d   = skid_q;
                skid_v_d = accept;
                if (accept)
                    skid_d = dec_bundle;
            end else begin
                main_v_d = accept;
                if (accept)
                    main_d = dec_bundle;
            end
        end else if (accept) begin
            skid_v_d = 1'b1;
            skid_d   = dec_bundle;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
        end
    end

    assign id_valid    = main_v_q;
    assign id_pc       = main_q.pc;
    assign id_imm      = main_q.imm;
    assign id_rs1      = main_q.ctrl.rs1;
    assign id_rs2      = main_q.ctrl.rs2;
    assign id_rd       = main_q.ctrl.rd;
    assign id_alu_op   = main_q.ctrl.alu_op;
    assign id_a_sel    = main_q.ctrl.a_sel;
    assign id_b_sel    = main_q.ctrl.b_sel;
    assign id_word     = main_q.ctrl.word;
    assign id_br_op    = main_q.ctrl.br_op;
    assign id_jump     = main_q.ctrl.jump;
    assign id_reg_wen  = main_q.ctrl.reg_wen;
    assign id_wb_sel   = main_q.ctrl.wb_sel;
    assign id_mem_ren  = main_q.ctrl.mem_ren;
    assign id_mem_wen  = main_q.ctrl.mem_wen;
    assign id_mem_size = main_q.ctrl.mem_size;
    assign id_illegal  = main_q.ctrl.illegal;
    assign id_ebreak   = main_q.ctrl.ebreak;

endmodule

// File: doc/ysyx_22040759_idu_stage.md
Name: ysyx_22040759_idu_stage

Overview:
Registered instruction-decode stage between IFU and EXU. It is the parametrised successor to the purely combinational decoder:
- Width and RV64 support are configurable by XLEN.
- Covers full RV32I/RV64I base decode, including all branches, loads/stores of every size and word ops.
- Adds a valid/ready handshake on both sides with a 2-entry skid buffer, a pipeline flush and illegal-instruction flagging.
- Decode is combinational on the accepted instruction; results are held in the stage registers.

Parameters:
XLEN, 64, datapath width; 32 or 64 only; 32 makes RV64-only encodings illegal.
PC_W, XLEN, PC width.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
flush  in  1  discard all held/incoming instructions this cycle
if_valid  in  1  IFU offers instruction
if_ready  out  1  stage can accept
if_inst  in  32  instruction word
if_pc  in  PC_W  instruction PC
id_valid  out  1  decoded bundle valid
id_ready  in  1  EXU accepts bundle
id_pc  out  PC_W  PC of bundle
id_imm  out  XLEN  sign-extended immediate (I/S/B/U/J per opcode)
id_rs1, id_rs2, id_rd  out  5  register addresses
id_alu_op  out  5  ALU op code (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, NOP)
id_a_sel  out  2  A operand: REG/PC/ZERO
id_b_sel  out  2  B operand: REG/IMM
id_word  out  1  32-bit op with result sign-extension (RV64 *W forms)
id_br_op  out  3  NONE/BEQ/BNE/BLT/BGE/BLTU/BGEU
id_jump  out  2  NONE/JAL/JALR
id_reg_wen  out  1  writeback enable (forced 0 when rd==0)
id_wb_sel  out  2  ALU/MEM/PC+4
id_mem_ren, id_mem_wen  out  1  load / store
id_mem_size  out  3  funct3 of load/store (size + unsigned)
id_illegal  out  1  unsupported/illegal encoding
id_ebreak  out  1  EBREAK decoded (simulation halt)

Behaviour:
- Reset (rst_n low at clock edge): main and skid valid cleared. id_valid=0, if_ready=1, all id_* bundle fields 0. Reset mid-handshake drops the in-flight instruction.
- Storage: main register (drives id_*) plus one skid register, each holding the decoded bundle. Decode happens before storage.
- if_ready = !skid_valid (registered, no combinational path from id_ready).
- Accept when if_valid && if_ready.
- Output handshake: consume when id_valid && id_ready.
- Latency: instruction accepted in cycle N appears on id_* in cycle N+1 when the main register is empty or being consumed.
- Per-cycle update, in priority order:
  1. flush: main and skid valid cleared; the accept in the same cycle is discarded.
  2. Main empty or consumed:
     - skid valid: skid moves to main, and the new accept (if any) goes to skid.
     - skid empty: the accept goes to main.
  3. Main held (valid && !id_ready): the accept goes to skid.
- Ordering is strictly preserved. No bundle is duplicated or dropped except by flush or reset.
- Bundle fields are stable while id_valid && !id_ready.
- Immediate formats:
  - U: {inst[31:12], 12'b0}, sign-extended to XLEN.
  - I, S, B, J: standard, sign-extended.
  - R-type: imm = 0.
- LUI uses a_sel=ZERO, AUIPC uses a_sel=PC.
- JAL/JALR: alu_op=ADD, wb_sel=PC+4. JALR result LSB clearing is done in EXU.
- Branches: alu_op=SUB, reg_wen=0, br_op per funct3. funct3 010/011 is illegal.
- Shift immediates:
  - XLEN=64: shamt is 6 bits.
  - XLEN=32: inst[25]=1 is illegal.
  - *W shifts: inst[25]=1 is illegal.
- XLEN=32: opcodes OP-32 and OP-IMM-32, LD/LWU/SD and funct3=011 loads/stores are illegal.
- Illegal instruction (including all-zero and unknown opcode/funct):
  - Flags: id_illegal=1, reg_wen=0, mem_ren=mem_wen=0, br_op=NONE, jump=NONE, alu_op=NOP.
  - Passes down the pipe like a normal bundle; no simulation print.
- EBREAK (0x00100073): id_ebreak=1, no writes. ECALL and other SYSTEM encodings are illegal.
- FENCE is decoded as NOP (not illegal).

Decomposition:
- Shared package/define file ysyx_22040759_define:
  - ALU op, a_sel/b_sel, br_op, jump, wb_sel codes.
  - Opcode constants.
  - Decoded-bundle width/field offsets, so EXU reuses them.
- Sub-module ysyx_22040759_idu_dec: purely combinational inst -> bundle, parametrised by XLEN.
- The stage module holds only the handshake, skid and flush logic.

Test Plan:
1. 0xFFF10093 (addi x1,x2,-1), id_ready=1 -> next cycle id_valid=1, rd=1, rs1=2, imm=all ones, alu_op=ADD, b_sel=IMM, reg_wen=1.
2. 0xFE209EE3 (bne x1,x2,-4) -> br_op=BNE, imm=-4, reg_wen=0, alu_op=SUB.
3. Back-pressure: id_ready=0 for 3 cycles while offering A, B, C -> if_ready drops after B accepted; C held at IFU. After id_ready=1, output order is A, B, C with no loss.
4. Flush with main and skid full plus if_valid=1 -> next cycle id_valid=0, if_ready=1. Nothing from before the flush ever appears.
5. 0x00000000 and 0x0000003B (addw) with XLEN=32 -> id_illegal=1, reg_wen=0. Same addw with XLEN=64 -> legal, id_word=1.
6. rst_n=0 for one cycle while id_valid=1 -> id_valid=0, all fields 0, if_ready=1 on the following cycle.
